// File: rtl/qpsk_pkg.sv
// Shared constants and state encoding for the QPSK symbol sequencer.
// Q16.16 symbol amplitudes and the sequencer FSM state type.
package qpsk_pkg;

  // +/- 0.7071 in Q16.16
  localparam logic signed [31:0] QPSK_POS = 32'sh0000_B505;
  localparam logic signed [31:0] QPSK_NEG = 32'shFFFF_4AFB;

  // State encodings (PRE is only reachable when the preamble is compiled in)
  localparam logic [1:0] IDLE_ENC = 2'd0;
  localparam logic [1:0] HALF_ENC = 2'd1;
  localparam logic [1:0] PRE_ENC  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = IDLE_ENC,
    HALF = HALF_ENC,
    PRE  = PRE_ENC
  } seq_state_t;

endpackage

// File: rtl/qpsk_symbol_sequencer_if.sv
// Bit-stream input and symbol-stream output bundle of the QPSK sequencer.
// master: the sequencer itself; slave: the surrounding environment.
interface qpsk_symbol_sequencer_if #(
  parameter int CNT_W = 16
);
  logic                    bit_in;
  logic                    bit_valid;
  logic                    bit_last;
  logic                    bit_ready;
  logic signed [31:0]      sym_re;
  logic signed [31:0]      sym_im;
  logic                    sym_valid;
  logic                    sym_last;
  logic                    sym_ready;
  logic [CNT_W-1:0]        frame_sym_cnt;

  modport master (
    input  bit_in, bit_valid, bit_last, sym_ready,
    output bit_ready, sym_re, sym_im, sym_valid, sym_last, frame_sym_cnt
  );

  modport slave (
    output bit_in, bit_valid, bit_last, sym_ready,
    input  bit_ready, sym_re, sym_im, sym_valid, sym_last, frame_sym_cnt
  );
endinterface

// File: rtl/mapper.sv
// Combinational QPSK mapper: bit1 selects the real part, bit2 the imaginary.
// A 0 bit maps to +0.7071, a 1 bit to -0.7071 (Q16.16).
module mapper
  import qpsk_pkg::*;
(
  input  logic               bit1,
  input  logic               bit2,
  output logic signed [31:0] re,
  output logic signed [31:0] im
);
  assign re = bit1 ? QPSK_NEG : QPSK_POS;
  assign im = bit2 ? QPSK_NEG : QPSK_POS;
endmodule

// File: rtl/qpsk_symbol_sequencer.sv
// QPSK symbol sequencer: pairs a serial bit stream MSB-first, maps each pair
// through the mapper and holds the result in a one-entry output register with
// valid/ready backpressure. Odd frames are padded with PAD_BIT; data symbols
// per frame are counted (saturating).
// Optional build macro QPSK_SEQ_PREAMBLE_EN: prepend PREAMBLE_LEN fixed
// symbols taken from PREAMBLE_PAT at the start of every frame.
module qpsk_symbol_sequencer
  import qpsk_pkg::*;
#(
  parameter logic PAD_BIT = 1'b0,
  parameter int   CNT_W   = 16
`ifdef QPSK_SEQ_PREAMBLE_EN
  ,
  parameter int                        PREAMBLE_LEN = 4,
  parameter logic [2*PREAMBLE_LEN-1:0] PREAMBLE_PAT = 8'b00_11_01_10
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  qpsk_symbol_sequencer_if.master   io
);

  seq_state_t         state_reg;
  logic               held_reg;
  logic               sof_reg;
  logic               sym_valid_reg;
  logic               sym_last_reg;
  logic signed [31:0] sym_re_reg;
  logic signed [31:0] sym_im_reg;
  logic [CNT_W-1:0]   cnt_reg;

  logic               out_free;
  logic               accept_state;
  logic               accept_ok;
  logic               bit_fire;
  logic               load_data;
  logic               map_b1;
  logic               map_b2;
  logic signed [31:0] map_re;
  logic signed [31:0] map_im;
  logic [CNT_W-1:0]   cnt_inc;

`ifdef QPSK_SEQ_PREAMBLE_EN
  logic [2:0] pre_idx_reg;
  logic       need_pre_reg;
  logic [1:0] pre_tab [8];

  // Unpack the preamble pattern into an 8-entry pair table, MSB pair first
  for (genvar gi = 0; gi < 8; gi++) begin : g_pre_tab
    if (gi < PREAMBLE_LEN) begin : g_used
      assign pre_tab[gi] = PREAMBLE_PAT[2*PREAMBLE_LEN-1-2*gi -: 2];
    end else begin : g_unused
      assign pre_tab[gi] = 2'b00;
    end
  end

  // While a preamble is owed, IDLE must not swallow the first frame bit
  assign accept_state = (state_reg == HALF) || (state_reg == IDLE && !need_pre_reg);
`else
  assign accept_state = (state_reg == IDLE) || (state_reg == HALF);
`endif

  // Output register may be (re)loaded when empty or draining this cycle
  assign out_free  = !sym_valid_reg || io.sym_ready;
  assign accept_ok = rst_n && accept_state && out_free;
  assign bit_fire  = io.bit_valid && accept_ok;
  // A data symbol completes on the second bit of a pair or on an odd last bit
  assign load_data = bit_fire && ((state_reg == HALF) || io.bit_last);

  // Select the bit pair presented to the mapper for the current state
  always_comb begin
    map_b1 = io.bit_in;
    map_b2 = PAD_BIT;
    case (state_reg)
      HALF: begin
        map_b1 = held_reg;
        map_b2 = io.bit_in;
      end
`ifdef QPSK_SEQ_PREAMBLE_EN
      PRE: begin
        map_b1 = pre_tab[pre_idx_reg][1];
        map_b2 = pre_tab[pre_idx_reg][0];
      end
`endif
      default: ;
    endcase
  end

  // Next symbol count: restart at 1 on the first data symbol of a frame, else saturate
  always_comb begin
    if (sof_reg) begin
      cnt_inc = CNT_W'(1);
    end else if (&cnt_reg) begin
      cnt_inc = cnt_reg;
    end else begin
      cnt_inc = cnt_reg + CNT_W'(1);
    end
  end

  mapper u_mapper (
    .bit1 (map_b1),
    .bit2 (map_b2),
    .re   (map_re),
    .im   (map_im)
  );

  // Sequencer FSM with registered symbol output stage and frame counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      held_reg      <= 1'b0;
      sof_reg       <= 1'b1;
      sym_valid_reg <= 1'b0;
      sym_last_reg  <= 1'b0;
      sym_re_reg    <= '0;
      sym_im_reg    <= '0;
      cnt_reg       <= '0;
`ifdef QPSK_SEQ_PREAMBLE_EN
      pre_idx_reg   <= 3'd0;
      need_pre_reg  <= 1'b1;
`endif
    end else begin
      if (sym_valid_reg && io.sym_ready) begin
        sym_valid_reg <= 1'b0;
      end

      // A same-cycle load overrides the drain above
      if (load_data) begin
        sym_valid_reg <= 1'b1;
        sym_re_reg    <= map_re;
        sym_im_reg    <= map_im;
        sym_last_reg  <= io.bit_last;
        cnt_reg       <= cnt_inc;
        sof_reg       <= io.bit_last;
`ifdef QPSK_SEQ_PREAMBLE_EN
        need_pre_reg  <= io.bit_last;
`endif
      end

      case (state_reg)
        IDLE: begin
`ifdef QPSK_SEQ_PREAMBLE_EN
          if (need_pre_reg && io.bit_valid) begin
            state_reg   <= PRE;
            pre_idx_reg <= 3'd0;
          end
`endif
          if (bit_fire && !io.bit_last) begin
            held_reg  <= io.bit_in;
            state_reg <= HALF;
          end
        end
        HALF: begin
          if (bit_fire) begin
            state_reg <= IDLE;
          end
        end
`ifdef QPSK_SEQ_PREAMBLE_EN
        PRE: begin
          if (out_free) begin
            sym_valid_reg <= 1'b1;
            sym_re_reg    <= map_re;
            sym_im_reg    <= map_im;
            sym_last_reg  <= 1'b0;
            pre_idx_reg   <= pre_idx_reg + 3'd1;
            if (pre_idx_reg == 3'(PREAMBLE_LEN - 1)) begin
              state_reg    <= IDLE;
              need_pre_reg <= 1'b0;
            end
          end
        end
`endif
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign io.bit_ready     = accept_ok;
  assign io.sym_valid     = sym_valid_reg;
  assign io.sym_last      = sym_last_reg;
  assign io.sym_re        = sym_re_reg;
  assign io.sym_im        = sym_im_reg;
  assign io.frame_sym_cnt = cnt_reg;

endmodule

// File: tb/tb_qpsk_symbol_sequencer.sv
// Scoreboard bench for qpsk_symbol_sequencer: directed frames push their
// hand-computed symbols into per-instance queues, monitors pop on each
// symbol transfer. Unit 0 uses CNT_W=16, unit 1 uses CNT_W=2 (saturation).
// Build with QPSK_SEQ_PREAMBLE_EN to also expect the frame preamble.
module tb_qpsk_symbol_sequencer;

  localparam logic [31:0] P = 32'h0000_B505;
  localparam logic [31:0] N = 32'hFFFF_4AFB;

  typedef struct {
    logic [31:0] re;
    logic [31:0] im;
    logic        last;
    int          cnt;
    bit          cnt_chk;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qpsk_symbol_sequencer_if #(.CNT_W(16)) bus   ();
  qpsk_symbol_sequencer_if #(.CNT_W(2))  bus_s ();

  qpsk_symbol_sequencer #(.PAD_BIT(1'b0), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  qpsk_symbol_sequencer #(.PAD_BIT(1'b0), .CNT_W(2)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus_s)
  );

  exp_t sb0[$];
  exp_t sb1[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic expect_sym(input int u, input logic [31:0] re, input logic [31:0] im,
                            input logic last, input int cnt);
    exp_t e;
    e.re = re; e.im = im; e.last = last; e.cnt = cnt; e.cnt_chk = 1'b1;
    if (u == 0) sb0.push_back(e); else sb1.push_back(e);
  endtask

  // Preamble pairs (0,0),(1,1),(0,1),(1,0); counter is not checked on them
  task automatic expect_pre(input int u);
`ifdef QPSK_SEQ_PREAMBLE_EN
    exp_t e;
    logic [31:0] re_t [4];
    logic [31:0] im_t [4];
    re_t = '{P, N, P, N};
    im_t = '{P, N, N, P};
    for (int k = 0; k < 4; k++) begin
      e.re = re_t[k]; e.im = im_t[k]; e.last = 1'b0; e.cnt = 0; e.cnt_chk = 1'b0;
      if (u == 0) sb0.push_back(e); else sb1.push_back(e);
    end
`else
    if (u < 0) $display("expect_pre: bad unit %0d", u);
`endif
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present one bit and wait (bounded) for it to be accepted
  task automatic send_bit(input int u, input bit b, input bit last);
    bit rdy;
    bit acc;
    int w;
    if (u == 0) begin
      bus.bit_in = b; bus.bit_valid = 1'b1; bus.bit_last = last;
    end else begin
      bus_s.bit_in = b; bus_s.bit_valid = 1'b1; bus_s.bit_last = last;
    end
    acc = 1'b0;
    w = 0;
    while (!acc && w < 64) begin
      @(negedge clk);
      rdy = (u == 0) ? bus.bit_ready : bus_s.bit_ready;
      @(posedge clk);
      acc = rdy;
      w++;
    end
    #1;
    n_vec++;
    if (!acc) begin
      n_bad++;
      $display("FAIL bit_accept unit=%0d: bit_ready stayed 0, required 1 within 64 cycles", u);
    end
    $display("unit%0d bit=%0d last=%0d accepted=%0d", u, b, last, acc);
  endtask

  task automatic idle(input int u);
    if (u == 0) begin bus.bit_valid = 1'b0; bus.bit_last = 1'b0; end
    else begin bus_s.bit_valid = 1'b0; bus_s.bit_last = 1'b0; end
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  // Monitor for unit 0: compare every symbol transfer against the queue head
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.sym_valid && bus.sym_ready) begin
      n_vec++;
      if (sb0.size() == 0) begin
        n_bad++;
        $display("FAIL sym_unexpected unit0: got re=%h im=%h last=%b, required no symbol",
                 bus.sym_re, bus.sym_im, bus.sym_last);
      end else begin
        e = sb0.pop_front();
        if (bus.sym_re !== e.re || bus.sym_im !== e.im || bus.sym_last !== e.last ||
            (e.cnt_chk && int'(bus.frame_sym_cnt) != e.cnt)) begin
          n_bad++;
          $display("FAIL sym unit0: got re=%h im=%h last=%b cnt=%0d, expected re=%h im=%h last=%b cnt=%0d",
                   bus.sym_re, bus.sym_im, bus.sym_last, bus.frame_sym_cnt, e.re, e.im, e.last, e.cnt);
        end else begin
          $display("unit0 sym re=%h im=%h last=%b cnt=%0d ok", bus.sym_re, bus.sym_im,
                   bus.sym_last, bus.frame_sym_cnt);
        end
      end
    end
  end

  // Monitor for unit 1 (2-bit saturating counter)
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus_s.sym_valid && bus_s.sym_ready) begin
      n_vec++;
      if (sb1.size() == 0) begin
        n_bad++;
        $display("FAIL sym_unexpected unit1: got re=%h im=%h last=%b, required no symbol",
                 bus_s.sym_re, bus_s.sym_im, bus_s.sym_last);
      end else begin
        e = sb1.pop_front();
        if (bus_s.sym_re !== e.re || bus_s.sym_im !== e.im || bus_s.sym_last !== e.last ||
            (e.cnt_chk && int'(bus_s.frame_sym_cnt) != e.cnt)) begin
          n_bad++;
          $display("FAIL sym unit1: got re=%h im=%h last=%b cnt=%0d, expected re=%h im=%h last=%b cnt=%0d",
                   bus_s.sym_re, bus_s.sym_im, bus_s.sym_last, bus_s.frame_sym_cnt, e.re, e.im, e.last, e.cnt);
        end else begin
          $display("unit1 sym re=%h im=%h last=%b cnt=%0d ok", bus_s.sym_re, bus_s.sym_im,
                   bus_s.sym_last, bus_s.frame_sym_cnt);
        end
      end
    end
  end

  initial begin
    logic [9:0] sat_bits;
    int w;
    bus.bit_in = 1'b0;   bus.bit_valid = 1'b0;   bus.bit_last = 1'b0;   bus.sym_ready = 1'b1;
    bus_s.bit_in = 1'b0; bus_s.bit_valid = 1'b0; bus_s.bit_last = 1'b0; bus_s.sym_ready = 1'b1;
    rst_n = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bit_ready",  32'(bus.bit_ready), 32'd0);
    chk("rst_sym_valid",  32'(bus.sym_valid), 32'd0);
    chk("rst_sym_last",   32'(bus.sym_last), 32'd0);
    chk("rst_sym_re",     bus.sym_re, 32'd0);
    chk("rst_sym_im",     bus.sym_im, 32'd0);
    chk("rst_cnt",        32'(bus.frame_sym_cnt), 32'd0);
    chk("rst_sat_ready",  32'(bus_s.bit_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Frame 1,0,1,1
    expect_pre(0);
    expect_sym(0, N, P, 1'b0, 1);
    expect_sym(0, N, N, 1'b1, 2);
    send_bit(0, 1, 0); send_bit(0, 0, 0); send_bit(0, 1, 0); send_bit(0, 1, 1);
    idle(0);
    drain();
    @(negedge clk);
    chk("frame1_cnt", 32'(bus.frame_sym_cnt), 32'd2);
    @(posedge clk); #1;

    // Odd frame 0,1,0 padded with PAD_BIT=0
    expect_pre(0);
    expect_sym(0, P, N, 1'b0, 1);
    expect_sym(0, P, P, 1'b1, 2);
    send_bit(0, 0, 0); send_bit(0, 1, 0); send_bit(0, 0, 1);
    idle(0);
    drain();

    // Backpressure: symbol pending while sym_ready=0 for 5 cycles
    expect_pre(0);
    expect_sym(0, N, N, 1'b0, 1);
    expect_sym(0, P, N, 1'b1, 2);
    send_bit(0, 1, 0);
    bus.sym_ready = 1'b0;
    send_bit(0, 1, 0);
    bus.bit_in = 1'b0; bus.bit_valid = 1'b1; bus.bit_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_bit_ready",  32'(bus.bit_ready), 32'd0);
      chk("bp_sym_valid",  32'(bus.sym_valid), 32'd1);
      chk("bp_sym_re",     bus.sym_re, N);
      chk("bp_sym_im",     bus.sym_im, N);
    end
    @(posedge clk); #1;
    bus.sym_ready = 1'b1;
    send_bit(0, 0, 0); send_bit(0, 1, 1);
    idle(0);
    drain();

    // Reset with a symbol pending: it is discarded
    expect_pre(0);
    send_bit(0, 1, 0);
    bus.sym_ready = 1'b0;
    send_bit(0, 0, 0);
    idle(0);
    @(negedge clk);
    chk("pend_sym_valid", 32'(bus.sym_valid), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb0.delete(); sb1.delete();
    @(negedge clk);
    chk("rst2_sym_valid", 32'(bus.sym_valid), 32'd0);
    chk("rst2_cnt",       32'(bus.frame_sym_cnt), 32'd0);
    chk("rst2_sym_re",    bus.sym_re, 32'd0);
    @(posedge clk); #1;
    bus.sym_ready = 1'b1;

    // Reset while HALF: held bit 1 is dropped, next bit is b1 again
    expect_pre(0);
    send_bit(0, 1, 0);
    idle(0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb0.delete(); sb1.delete();
    drain();
    expect_pre(0);
    expect_sym(0, P, P, 1'b1, 1);
    send_bit(0, 0, 0); send_bit(0, 0, 1);
    idle(0);
    drain();

    // Saturation on CNT_W=2: 5-symbol frame
    sat_bits = 10'b10_01_11_00_10;
    expect_pre(1);
    expect_sym(1, N, P, 1'b0, 1);
    expect_sym(1, P, N, 1'b0, 2);
    expect_sym(1, N, N, 1'b0, 3);
    expect_sym(1, P, P, 1'b0, 3);
    expect_sym(1, N, P, 1'b1, 3);
    for (int i = 9; i >= 0; i--) begin
      send_bit(1, sat_bits[i], i == 0);
    end
    idle(1);
    drain();
    @(negedge clk);
    chk("sat_cnt", 32'(bus_s.frame_sym_cnt), 32'd3);

    // All expected symbols must have been seen
    w = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && w < 100) begin
      @(posedge clk);
      w++;
    end
    chk("sb0_left", 32'(sb0.size()), 32'd0);
    chk("sb1_left", 32'(sb1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
